// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART transmitter.
package uart_pkg;

    // Transmitter FSM states, in the order they occur within a frame.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Parity selection after decoding the 2-bit mode input.
    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    // Shortest frame payload and shortest bit period the transmitter produces.
    localparam int MIN_DATA_BITS    = 5;
    localparam int MIN_CLKS_PER_BIT = 2;

    // Mode 3 is reserved and behaves as "no parity".
    function automatic parity_e decode_parity(input logic [1:0] mode);
        case (mode)
            2'd1:    return PAR_ODD;
            2'd2:    return PAR_EVEN;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO with a combinational head word, used to queue
// words ahead of the transmitter so frames can run back-to-back.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         i_Clock,
    input  logic                         i_Rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    logic push_ok;
    logic pop_ok;

    // Requests against a full or empty queue are simply dropped.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign head  = mem[rd_ptr_reg];

    // Storage array: written only on an accepted push, never cleared.
    always_ff @(posedge i_Clock) begin
        if (i_Rst_n && push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap freely.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: FIFO-fed, programmable bit period,
// data length, parity and stop bits. Frames are sent back-to-back whenever
// the FIFO still holds words at the end of a stop period.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKDIV_WIDTH = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                                i_Clock,
    input  logic                                i_Rst_n,
    input  logic [CLKDIV_WIDTH-1:0]             i_Clks_Per_Bit,
    input  logic [$clog2(DATA_WIDTH+1)-1:0]     i_Data_Bits,
    input  logic [1:0]                          i_Parity_Mode,
    input  logic                                i_Two_Stop,
    input  logic                                i_Tx_Valid,
    input  logic [DATA_WIDTH-1:0]               i_Tx_Byte,
    output logic                                o_Tx_Ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     o_Fifo_Count,
    output logic                                o_Tx_Active,
    output logic                                o_Tx_Serial,
    output logic                                o_Tx_Done
);

    localparam int NB_W = $clog2(DATA_WIDTH+1);
    localparam int FC_W = $clog2(FIFO_DEPTH+1);

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FC_W-1:0]       fifo_count;
    logic                  fifo_push;
    logic                  fifo_pop;

    // Ready is forced low while reset is held so nothing is queued then.
    assign o_Tx_Ready   = i_Rst_n && !fifo_full;
    assign fifo_push    = i_Tx_Valid && o_Tx_Ready;
    assign o_Fifo_Count = fifo_count;

    uart_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_Clock (i_Clock),
        .i_Rst_n (i_Rst_n),
        .push    (fifo_push),
        .wr_data (i_Tx_Byte),
        .pop     (fifo_pop),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // ------------------------------------------------------------------
    // Configuration clamping, evaluated on the live inputs and captured
    // only when a word is popped, so mid-frame changes wait a frame.
    // ------------------------------------------------------------------
    logic [CLKDIV_WIDTH-1:0] cpb_clamped;
    logic [NB_W-1:0]         nbits_clamped;
    parity_e                 par_sel;
    logic [DATA_WIDTH-1:0]   head_masked;
    logic                    head_parity;

    assign cpb_clamped = (i_Clks_Per_Bit < CLKDIV_WIDTH'(MIN_CLKS_PER_BIT))
                       ? CLKDIV_WIDTH'(MIN_CLKS_PER_BIT) : i_Clks_Per_Bit;

    assign nbits_clamped = (i_Data_Bits < NB_W'(MIN_DATA_BITS)) ? NB_W'(MIN_DATA_BITS)
                         : (i_Data_Bits > NB_W'(DATA_WIDTH))    ? NB_W'(DATA_WIDTH)
                         : i_Data_Bits;

    assign par_sel = decode_parity(i_Parity_Mode);

    // Bits above the active length must not contribute to parity.
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_mask
        assign head_masked[gi] = fifo_head[gi] & (nbits_clamped > NB_W'(gi));
    end

    // Even parity is the plain XOR; odd parity is its inverse.
    assign head_parity = (^head_masked) ^ (par_sel == PAR_ODD);

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    tx_state_e               state_reg,   state_next;
    logic [CLKDIV_WIDTH-1:0] cnt_reg,     cnt_next;
    logic [NB_W-1:0]         bit_idx_reg, bit_idx_next;
    logic [DATA_WIDTH-1:0]   shift_reg,   shift_next;
    logic                    stop_idx_reg, stop_idx_next;
    logic                    serial_reg,  serial_next;
    logic                    active_reg,  active_next;
    logic                    done_reg,    done_next;

    // Per-frame configuration captured at pop time.
    logic [CLKDIV_WIDTH-1:0] cpb_reg;
    logic [NB_W-1:0]         nbits_reg;
    parity_e                 par_reg;
    logic                    two_stop_reg;
    logic                    par_bit_reg;

    logic load;
    logic bit_end;
    logic last_bit;

    assign fifo_pop = load;
    assign bit_end  = (cnt_reg == cpb_reg - CLKDIV_WIDTH'(1));
    assign last_bit = (bit_idx_reg == nbits_reg - NB_W'(1));

    assign o_Tx_Serial = serial_reg;
    assign o_Tx_Active = active_reg;
    assign o_Tx_Done   = done_reg;

    // Next-state, bit timing and registered line value for the coming cycle.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        bit_idx_next  = bit_idx_reg;
        shift_next    = shift_reg;
        stop_idx_next = stop_idx_reg;
        serial_next   = serial_reg;
        active_next   = active_reg;
        done_next     = 1'b0;
        load          = 1'b0;

        // Bit counter runs 0..CPB-1 in every non-idle state.
        if (state_reg != ST_IDLE) begin
            cnt_next = bit_end ? '0 : cnt_reg + CLKDIV_WIDTH'(1);
        end

        case (state_reg)
            ST_IDLE: begin
                cnt_next    = '0;
                serial_next = 1'b1;
                active_next = 1'b0;
                if (!fifo_empty) begin
                    load        = 1'b1;
                    state_next  = ST_START;
                    serial_next = 1'b0;
                    active_next = 1'b1;
                end
            end

            ST_START: begin
                if (bit_end) begin
                    state_next   = ST_DATA;
                    bit_idx_next = '0;
                    serial_next  = shift_reg[0];
                end
            end

            ST_DATA: begin
                if (bit_end) begin
                    if (last_bit) begin
                        if (par_reg != PAR_NONE) begin
                            state_next  = ST_PARITY;
                            serial_next = par_bit_reg;
                        end else begin
                            state_next    = ST_STOP;
                            stop_idx_next = 1'b0;
                            serial_next   = 1'b1;
                        end
                    end else begin
                        // LSB first: the next bit to send sits at index 1.
                        bit_idx_next = bit_idx_reg + NB_W'(1);
                        shift_next   = shift_reg >> 1;
                        serial_next  = shift_reg[1];
                    end
                end
            end

            ST_PARITY: begin
                if (bit_end) begin
                    state_next    = ST_STOP;
                    stop_idx_next = 1'b0;
                    serial_next   = 1'b1;
                end
            end

            ST_STOP: begin
                if (bit_end) begin
                    if (two_stop_reg && !stop_idx_reg) begin
                        stop_idx_next = 1'b1;
                    end else begin
                        done_next = 1'b1;
                        if (!fifo_empty) begin
                            // Chain straight into the next frame, no idle gap.
                            load        = 1'b1;
                            state_next  = ST_START;
                            serial_next = 1'b0;
                        end else begin
                            state_next  = ST_IDLE;
                            active_next = 1'b0;
                            serial_next = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_next  = ST_IDLE;
                serial_next = 1'b1;
                active_next = 1'b0;
            end
        endcase

        if (load) begin
            shift_next = fifo_head;
        end
    end

    // State register plus per-frame configuration capture on each pop.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            stop_idx_reg <= 1'b0;
            serial_reg   <= 1'b1;
            active_reg   <= 1'b0;
            done_reg     <= 1'b0;
            cpb_reg      <= CLKDIV_WIDTH'(MIN_CLKS_PER_BIT);
            nbits_reg    <= NB_W'(MIN_DATA_BITS);
            par_reg      <= PAR_NONE;
            two_stop_reg <= 1'b0;
            par_bit_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_idx_reg  <= bit_idx_next;
            shift_reg    <= shift_next;
            stop_idx_reg <= stop_idx_next;
            serial_reg   <= serial_next;
            active_reg   <= active_next;
            done_reg     <= done_next;
            if (load) begin
                cpb_reg      <= cpb_clamped;
                nbits_reg    <= nbits_clamped;
                par_reg      <= par_sel;
                two_stop_reg <= i_Two_Stop;
                par_bit_reg  <= head_parity;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: directed test-plan cases followed by
// randomized bursts, compared cycle by cycle against a frame-level model.
module tb_uart_tx_cfg;

    localparam int DW    = 8;
    localparam int CW    = 16;
    localparam int DEPTH = 4;
    localparam int NBW   = $clog2(DW+1);
    localparam int FCW   = $clog2(DEPTH+1);

    logic            i_Clock = 1'b0;
    logic            i_Rst_n;
    logic [CW-1:0]   i_Clks_Per_Bit;
    logic [NBW-1:0]  i_Data_Bits;
    logic [1:0]      i_Parity_Mode;
    logic            i_Two_Stop;
    logic            i_Tx_Valid;
    logic [DW-1:0]   i_Tx_Byte;
    logic            o_Tx_Ready;
    logic [FCW-1:0]  o_Fifo_Count;
    logic            o_Tx_Active;
    logic            o_Tx_Serial;
    logic            o_Tx_Done;

    always #5 i_Clock = ~i_Clock;

    uart_tx_cfg #(
        .DATA_WIDTH   (DW),
        .CLKDIV_WIDTH (CW),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_Clock        (i_Clock),
        .i_Rst_n        (i_Rst_n),
        .i_Clks_Per_Bit (i_Clks_Per_Bit),
        .i_Data_Bits    (i_Data_Bits),
        .i_Parity_Mode  (i_Parity_Mode),
        .i_Two_Stop     (i_Two_Stop),
        .i_Tx_Valid     (i_Tx_Valid),
        .i_Tx_Byte      (i_Tx_Byte),
        .o_Tx_Ready     (o_Tx_Ready),
        .o_Fifo_Count   (o_Fifo_Count),
        .o_Tx_Active    (o_Tx_Active),
        .o_Tx_Serial    (o_Tx_Serial),
        .o_Tx_Done      (o_Tx_Done)
    );

    // ---------------- reference model state ----------------
    int   mq[$];          // words waiting in the FIFO
    int   cur_bits[$];    // line levels of the frame in flight, one per bit period
    int   cur_cpb;
    int   elapsed;        // clocks since the current frame started
    bit   m_active;
    bit   m_done;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   frames   = 0;
    int   done_cycles[$];
    logic prev_done = 1'b0;
    logic ready_pre;
    bit   last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Frame = start 0, data LSB first, optional parity, one or two stop 1s.
    task automatic build_frame(input int word);
        int nb;
        int ones;
        cur_cpb = (i_Clks_Per_Bit < 2) ? 2 : int'(i_Clks_Per_Bit);
        nb = int'(i_Data_Bits);
        if (nb < 5)  nb = 5;
        if (nb > DW) nb = DW;
        cur_bits.delete();
        cur_bits.push_back(0);
        ones = 0;
        for (int b = 0; b < nb; b++) begin
            cur_bits.push_back((word >> b) & 1);
            ones += (word >> b) & 1;
        end
        if (i_Parity_Mode == 2'd2) cur_bits.push_back(ones % 2);
        else if (i_Parity_Mode == 2'd1) cur_bits.push_back(1 - (ones % 2));
        cur_bits.push_back(1);
        if (i_Two_Stop) cur_bits.push_back(1);
    endtask

    // Advance the model across one rising edge using the inputs held before it.
    task automatic model_edge();
        bit can_push;
        m_done = 1'b0;
        if (!i_Rst_n) begin
            mq.delete();
            m_active = 1'b0;
            elapsed  = 0;
            return;
        end
        can_push = i_Tx_Valid && (mq.size() < DEPTH);
        if (m_active) begin
            elapsed++;
            if (elapsed == cur_bits.size() * cur_cpb) begin
                m_done   = 1'b1;
                m_active = 1'b0;
            end
        end
        if (!m_active && mq.size() > 0) begin
            build_frame(mq.pop_front());
            m_active = 1'b1;
            elapsed  = 0;
        end
        if (can_push) mq.push_back(int'(i_Tx_Byte));
    endtask

    // One clock: check ready before the edge, check all outputs after it.
    task automatic step();
        int exp_serial;
        #1;
        ready_pre = o_Tx_Ready;
        chk("ready", 32'(o_Tx_Ready), 32'(i_Rst_n && (mq.size() < DEPTH)));
        last_acc = (ready_pre === 1'b1) && i_Tx_Valid;
        @(posedge i_Clock);
        cyc++;
        model_edge();
        #1;
        exp_serial = m_active ? cur_bits[elapsed / cur_cpb] : 1;
        chk("serial",   32'(o_Tx_Serial),  32'(exp_serial));
        chk("active",   32'(o_Tx_Active),  32'(m_active));
        chk("done",     32'(o_Tx_Done),    32'(m_done));
        chk("count",    32'(o_Fifo_Count), 32'(mq.size()));
        chk("done_gap", 32'(prev_done & o_Tx_Done), 32'(0));
        prev_done = o_Tx_Done;
        if (o_Tx_Done === 1'b1) done_cycles.push_back(cyc);
        if (m_done) begin
            frames++;
            $display("frame %0d complete at cycle %0d (cpb=%0d, bits on line=%0d)",
                     frames, cyc, cur_cpb, cur_bits.size());
        end
        @(negedge i_Clock);
    endtask

    task automatic drain(input int limit);
        for (int k = 0; k < limit && (m_active || mq.size() > 0); k++) step();
        chk("drain_bound", 32'(m_active || (mq.size() > 0)), 32'(0));
        step();
        step();
    endtask

    // Push one word into an idle transmitter and check Done lands at E0+delta.
    task automatic send_single(input int word, input int delta, input string tag);
        int push_cyc;
        done_cycles.delete();
        i_Tx_Valid = 1'b1;
        i_Tx_Byte  = DW'(word);
        step();
        push_cyc   = cyc;
        i_Tx_Valid = 1'b0;
        drain(1000);
        chk(tag, (done_cycles.size() > 0) ? 32'(done_cycles[0] - push_cyc) : 32'hFFFF_FFFF,
            32'(delta));
    endtask

    task automatic set_cfg(input int cpb, input int nb, input int par, input int two);
        i_Clks_Per_Bit = CW'(cpb);
        i_Data_Bits    = NBW'(nb);
        i_Parity_Mode  = 2'(par);
        i_Two_Stop     = 1'(two);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int idx, first_acc, fifth_acc, sixth_acc, words, k;
        logic [7:0] stream [6];

        i_Rst_n    = 1'b0;
        i_Tx_Valid = 1'b0;
        i_Tx_Byte  = '0;
        set_cfg(4, 8, 0, 0);
        m_active = 1'b0;
        elapsed  = 0;
        cur_cpb  = 2;
        @(negedge i_Clock);

        // Reset state held for a few cycles, then release.
        repeat (3) step();
        i_Rst_n = 1'b1;
        step();

        // 8N1 at CPB=4: 10 bits x 4 clocks, Done at E1+40.
        set_cfg(4, 8, 0, 0);
        send_single(8'hA5, 41, "len_8n1");
        // Even and odd parity add one bit period.
        set_cfg(4, 8, 2, 0);
        send_single(8'hA5, 45, "len_8e1");
        set_cfg(4, 8, 1, 0);
        send_single(8'hA5, 45, "len_8o1");
        // 7 bits, even parity, two stops at CPB=3: 11 x 3 = 33 clocks.
        set_cfg(3, 7, 2, 1);
        send_single(8'hFF, 34, "len_7e2");
        // CPB=1 -> 2, Data_Bits=2 -> 5: 7 x 2 = 14 clocks.
        set_cfg(1, 2, 0, 0);
        send_single(8'h3C, 15, "len_clamped");

        // Valid held high with six bytes at CPB=16.
        set_cfg(16, 8, 0, 0);
        for (int i = 0; i < 6; i++) stream[i] = 8'(8'h13 + i * 8'h2B);
        done_cycles.delete();
        idx = 0; first_acc = -1; fifth_acc = -1; sixth_acc = -1;
        i_Tx_Valid = 1'b1;
        for (int n = 0; n < 2000 && idx < 6; n++) begin
            i_Tx_Byte = stream[idx];
            step();
            if (last_acc) begin
                if (idx == 0) first_acc = cyc;
                if (idx == 4) fifth_acc = cyc;
                if (idx == 5) sixth_acc = cyc;
                idx++;
            end
        end
        i_Tx_Valid = 1'b0;
        chk("burst_accepted", 32'(idx), 32'(6));
        chk("fifth_accept",   32'(fifth_acc - first_acc), 32'(4));
        chk("sixth_accept",   32'(sixth_acc - first_acc), 32'(162));
        drain(2000);
        chk("burst_frames", 32'(done_cycles.size()), 32'(6));
        for (int i = 1; i < 6; i++)
            chk("done_spacing",
                (i < done_cycles.size()) ? 32'(done_cycles[i] - done_cycles[i-1]) : 32'hFFFF_FFFF,
                32'(160));

        // Reset in the middle of DATA with two words still queued.
        set_cfg(8, 8, 0, 0);
        i_Tx_Valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_Tx_Byte = 8'(8'hC3 + i);
            step();
        end
        i_Tx_Valid = 1'b0;
        repeat (12) step();
        chk("pre_rst_count", 32'(o_Fifo_Count), 32'(2));
        i_Rst_n = 1'b0;
        step();
        chk("rst_mid_serial", 32'(o_Tx_Serial),  32'(1));
        chk("rst_mid_active", 32'(o_Tx_Active),  32'(0));
        chk("rst_mid_count",  32'(o_Fifo_Count), 32'(0));
        chk("rst_mid_done",   32'(o_Tx_Done),    32'(0));
        i_Rst_n = 1'b1;
        step();
        step();

        // Randomized bursts with configuration changes while frames are in flight.
        done_cycles.delete();
        words = 0;
        for (int t = 0; t < 20; t++) begin
            set_cfg($urandom_range(0, 5), $urandom_range(0, 15),
                    $urandom_range(0, 3), $urandom_range(0, 1));
            for (int w = 0; w < int'($urandom_range(1, 3)); w++) begin
                i_Tx_Valid = 1'b1;
                i_Tx_Byte  = DW'($urandom_range(0, 255));
                for (k = 0; k < 500; k++) begin
                    step();
                    if (last_acc) break;
                end
                chk("rand_accept_bound", 32'(k < 500), 32'(1));
                words++;
                i_Tx_Valid = 1'b0;
                repeat ($urandom_range(0, 30)) begin
                    if ($urandom_range(0, 3) == 0)
                        set_cfg($urandom_range(0, 5), $urandom_range(0, 15),
                                $urandom_range(0, 3), $urandom_range(0, 1));
                    step();
                end
            end
            drain(1500);
        end
        chk("rand_frames", 32'(done_cycles.size()), 32'(words));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
